// File: rtl/fpnew_sdotp_result_buffer.sv
// Elastic result FIFO behind the SDOTP wrapper: valid/ready toward the lane collector,
// sticky exception flags from unmasked pops, and back-pressure toward issue.
module fpnew_sdotp_result_buffer #(
    parameter int unsigned Width    = 64,
    parameter int unsigned Depth    = 2,
    parameter int unsigned TagWidth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [Width-1:0]             in_result_i,
    input  logic [4:0]                   in_status_i,
    input  logic                         in_ext_bit_i,
    input  logic                         in_mask_i,
    input  logic [TagWidth-1:0]          in_tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [Width-1:0]             out_result_o,
    output logic [4:0]                   out_status_o,
    output logic                         out_ext_bit_o,
    output logic                         out_mask_o,
    output logic [TagWidth-1:0]          out_tag_o,
    output logic [4:0]                   fflags_o,
    input  logic                         fflags_clr_i,
    output logic [$clog2(Depth+1)-1:0]   usage_o
);

    localparam int unsigned CntW   = $clog2(Depth + 1);
    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned EntryW = Width + 5 + 1 + 1 + TagWidth;

    logic [EntryW-1:0] mem_q [Depth];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   count_q;
    logic [4:0]        fflags_q, fflags_d;
    logic [EntryW-1:0] wdata, head;
    logic              push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        // Explicit wrap so non-power-of-two depths work.
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign in_ready_o  = (count_q < CntW'(Depth));
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i && in_ready_o && !flush_i;
    assign pop         = out_valid_o && out_ready_i;

    assign wdata = {in_result_i, in_status_i, in_ext_bit_i, in_mask_i, in_tag_i};
    assign head  = out_valid_o ? mem_q[rptr_q] : '0;
    assign {out_result_o, out_status_o, out_ext_bit_o, out_mask_o, out_tag_o} = head;

    always_comb begin
        fflags_d = fflags_clr_i ? 5'b0 : fflags_q;
        if (pop && out_mask_o) begin
            fflags_d = fflags_d | out_status_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
            if (flush_i) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) wptr_q <= ptr_inc(wptr_q);
                if (pop)  rptr_q <= ptr_inc(rptr_q);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CntW'(1);
                    2'b01:   count_q <= count_q - CntW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign fflags_o = fflags_q;
    assign usage_o  = count_q;

endmodule
